// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin data-bus arbiter with registered slave-side transaction.
// Optional slave timeout abort is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_strb,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_strb,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              s_valid,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [2:0]        s_strb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_next;
    logic   owner;
    logic   last_gnt;
    logic   win;
    logic   timed_out;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must be in 1..255");
    end

    // The master that was not served last wins a tie.
    assign win = m1_req & (~m0_req | ~last_gnt);

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    assign timed_out = (state == ACCESS) && !s_ready && (wait_cnt == 8'(TIMEOUT - 1));
    assign m0_err    = (state == RESP) && err_q && !owner;
    assign m1_err    = (state == RESP) && err_q && owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == ACCESS && !s_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
            err_q    <= timed_out;
        end
    end
`else
    assign timed_out = 1'b0;
    assign m0_err    = 1'b0;
    assign m1_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_next = ACCESS;
            ACCESS:  if (s_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign s_valid = (state == ACCESS);
    assign m0_gnt  = (state != IDLE) && !owner;
    assign m1_gnt  = (state != IDLE) && owner;
    assign m0_done = (state == RESP) && !owner;
    assign m1_done = (state == RESP) && owner;

    // Transaction latch, ownership bookkeeping and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_strb   <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner   <= win;
                        s_we    <= win ? m1_we    : m0_we;
                        s_addr  <= win ? m1_addr  : m0_addr;
                        s_wdata <= win ? m1_wdata : m0_wdata;
                        s_strb  <= win ? m1_strb  : m0_strb;
                    end
                end
                ACCESS: begin
                    if (s_ready) begin
                        if (!s_we) begin
                            if (owner) m1_rdata <= s_rdata;
                            else       m0_rdata <= s_rdata;
                        end
                    end else if (timed_out) begin
                        if (owner) m1_rdata <= '0;
                        else       m0_rdata <= '0;
                    end
                end
                RESP: last_gnt <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; timeout checks depend on BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [2:0]  m0_strb = '0;
    logic        m0_gnt, m0_done, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [2:0]  m1_strb = '0;
    logic        m1_gnt, m1_done, m1_err;
    logic [31:0] m1_rdata;
    logic        s_valid, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_strb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;

    int tests = 0;
    int fails = 0;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_strb(m0_strb), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_strb(m1_strb), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_strb(s_strb), .s_ready(s_ready), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_output("rst_s_valid", 32'(s_valid), 32'd0);
        check_output("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check_output("rst_m1_done", 32'(m1_done), 32'd0);
        check_output("rst_s_addr", s_addr, 32'h0);
        reset = 1'b0;
        tick();

        // m0 zero-wait read
        s_ready = 1'b1;
        s_rdata = 32'h1234_5678;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1000;
        check_output("rd_pre_valid", 32'(s_valid), 32'd0);
        tick();
        check_output("rd_s_valid", 32'(s_valid), 32'd1);
        check_output("rd_s_addr", s_addr, 32'h0000_1000);
        check_output("rd_s_we", 32'(s_we), 32'd0);
        check_output("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        check_output("rd_m0_done_early", 32'(m0_done), 32'd0);
        tick();
        check_output("rd_m0_done", 32'(m0_done), 32'd1);
        check_output("rd_s_valid_resp", 32'(s_valid), 32'd0);
        check_output("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        check_output("rd_m1_gnt", 32'(m1_gnt), 32'd0);
        check_output("rd_m1_done", 32'(m1_done), 32'd0);
        check_output("rd_m1_rdata", m1_rdata, 32'h0);
        check_output("rd_m0_err", 32'(m0_err), 32'd0);
        m0_req = 1'b0;
        tick();
        check_output("rd_m0_done_off", 32'(m0_done), 32'd0);
        check_output("rd_m0_gnt_off", 32'(m0_gnt), 32'd0);

        // Round-robin alternation with both masters requesting from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rdata = 32'h100 + 32'(i);
            tick();
            check_output($sformatf("rr%0d_m0_gnt", i), 32'(m0_gnt), 32'((i % 2) == 0));
            check_output($sformatf("rr%0d_m1_gnt", i), 32'(m1_gnt), 32'((i % 2) == 1));
            check_output($sformatf("rr%0d_s_addr", i), s_addr,
                         ((i % 2) == 0) ? 32'h0000_0100 : 32'h0000_0200);
            tick();
            check_output($sformatf("rr%0d_m0_done", i), 32'(m0_done), 32'((i % 2) == 0));
            check_output($sformatf("rr%0d_m1_done", i), 32'(m1_done), 32'((i % 2) == 1));
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();
        end
        check_output("rr_m0_rdata", m0_rdata, 32'h102);
        check_output("rr_m1_rdata", m1_rdata, 32'h103);

        // m1 write with three slave wait states
        s_ready = 1'b0;
        s_rdata = 32'hDEAD_BEEF;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_2004;
        m1_wdata = 32'hA5A5_A5A5; m1_strb = 3'b001;
        tick();
        for (int c = 0; c < 4; c++) begin
            check_output($sformatf("wr%0d_s_valid", c), 32'(s_valid), 32'd1);
            check_output($sformatf("wr%0d_s_we", c), 32'(s_we), 32'd1);
            check_output($sformatf("wr%0d_s_addr", c), s_addr, 32'h0000_2004);
            check_output($sformatf("wr%0d_s_wdata", c), s_wdata, 32'hA5A5_A5A5);
            check_output($sformatf("wr%0d_s_strb", c), 32'(s_strb), 32'd1);
            check_output($sformatf("wr%0d_m1_done", c), 32'(m1_done), 32'd0);
            if (c == 3) s_ready = 1'b1;
            tick();
        end
        check_output("wr_m1_done", 32'(m1_done), 32'd1);
        check_output("wr_s_valid_resp", 32'(s_valid), 32'd0);
        check_output("wr_m1_rdata", m1_rdata, 32'h103);
        check_output("wr_m0_rdata", m0_rdata, 32'h102);
        check_output("wr_m0_done", 32'(m0_done), 32'd0);
        m1_req = 1'b0; m1_we = 1'b0;
        s_ready = 1'b0;
        tick();

        // Request fields changed during ACCESS are ignored
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        s_rdata = 32'hCAFE_0010;
        tick();
        m0_addr = 32'h0000_0020;
        m0_we = 1'b1;
        tick();
        check_output("hold_s_addr_a", s_addr, 32'h0000_0010);
        check_output("hold_s_we", 32'(s_we), 32'd0);
        s_ready = 1'b1;
        tick();
        check_output("hold_m0_done", 32'(m0_done), 32'd1);
        check_output("hold_s_addr_b", s_addr, 32'h0000_0010);
        check_output("hold_m0_rdata", m0_rdata, 32'hCAFE_0010);
        m0_req = 1'b0; m0_we = 1'b0;
        s_ready = 1'b0;
        tick();

        // Reset pulse in the middle of ACCESS
        m0_req = 1'b1; m0_addr = 32'h0000_0040;
        tick();
        check_output("mid_s_valid_pre", 32'(s_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("mid_s_valid_rst", 32'(s_valid), 32'd0);
        check_output("mid_m0_gnt_rst", 32'(m0_gnt), 32'd0);
        check_output("mid_m0_done_rst", 32'(m0_done), 32'd0);
        check_output("mid_m0_rdata_rst", m0_rdata, 32'h0);
        check_output("mid_s_addr_rst", s_addr, 32'h0);
        tick();
        reset = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h0000_0080;
        check_output("mid_m0_done_rel", 32'(m0_done), 32'd0);
        s_rdata = 32'h55AA_55AA;
        tick();
        check_output("mid_tie_m0_gnt", 32'(m0_gnt), 32'd1);
        check_output("mid_tie_m1_gnt", 32'(m1_gnt), 32'd0);
        check_output("mid_tie_m0_done", 32'(m0_done), 32'd0);
        s_ready = 1'b1;
        tick();
        check_output("mid_tie_done", 32'(m0_done), 32'd1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        s_ready = 1'b0;
        tick();

        // Slave that never answers
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0300;
        tick();
`ifdef BUS_ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) tick();
        check_output("to_s_valid_8th", 32'(s_valid), 32'd1);
        check_output("to_m0_done_8th", 32'(m0_done), 32'd0);
        tick();
        check_output("to_m0_done", 32'(m0_done), 32'd1);
        check_output("to_m0_err", 32'(m0_err), 32'd1);
        check_output("to_m0_rdata", m0_rdata, 32'h0);
        check_output("to_s_valid", 32'(s_valid), 32'd0);
        m0_req = 1'b0;
        s_ready = 1'b1;
        tick();
        check_output("to_late_rdata", m0_rdata, 32'h0);
        check_output("to_late_err", 32'(m0_err), 32'd0);
        check_output("to_late_valid", 32'(s_valid), 32'd0);
        s_ready = 1'b0;
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            if (m0_done) check_output("nto_unexpected_done", 32'(m0_done), 32'd0);
        end
        check_output("nto_s_valid", 32'(s_valid), 32'd1);
        check_output("nto_m0_err", 32'(m0_err), 32'd0);
        check_output("nto_m0_rdata", m0_rdata, 32'h55AA_55AA);
        reset = 1'b1;
        m0_req = 1'b0;
        tick();
        reset = 1'b0;
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave data-bus arbiter placed between the RV32I core's data-bus port, a DMA/debug master and the shared memory/peripheral bus. It grants the slave to one master per transaction using round-robin priority. It registers and holds each transaction on the slave side until the slave acknowledges, then returns the completion and read data to the owning master. It lets a second master reach data memory and peripherals without modifying the core's datapath.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, slave wait-cycle limit; used only when BUS_ARB_TIMEOUT_EN is defined; range 1..255

Ports (mX = m0 core, m1 DMA; m1 ports mirror m0):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mX_req  in  1  transaction request; held high until mX_done
- mX_we  in  1  1 = write, 0 = read
- mX_addr  in  ADDR_W  byte address
- mX_wdata  in  DATA_W  write data
- mX_strb  in  3  access size/sign code (funct3 encoding), passed through
- mX_gnt  out  1  master X owns the slave bus (ACCESS and RESP)
- mX_done  out  1  one-cycle completion pulse
- mX_rdata  out  DATA_W  read data; updated only on read completion
- mX_err  out  1  timeout error, coincident with mX_done
- s_valid  out  1  transaction valid toward slave
- s_we, s_addr, s_wdata, s_strb  out  1/ADDR_W/DATA_W/3  latched transaction fields
- s_ready  in  1  slave acknowledge; for reads, s_rdata is valid in the same cycle
- s_rdata  in  DATA_W  slave read data

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - When any mX_req is high, select the winner and go to ACCESS.
  - Latch the winner's we/addr/wdata/strb into registers and record the owner.
  - Request-field changes after this latch are ignored.
- Arbitration (round-robin):
  - With one request, that master wins.
  - With two requests, the master not granted last wins.
  - After reset, "last granted" = m1, so m0 wins the first tie.
- ACCESS:
  - s_valid = 1 and s_* come from registers, held stable.
  - On a cycle with s_ready = 1: capture s_rdata into the owner's rdata register (reads only), then go to RESP.
- RESP:
  - s_valid = 0; owner's mX_done = 1 for one cycle.
  - Update "last granted" to the owner and go to IDLE.
- mX_gnt is high only for the owner, and only in ACCESS and RESP.
- The non-owner's outputs are unchanged while it waits.
- A master keeping req high after done is re-arbitrated in the next IDLE cycle. Two continuously requesting masters therefore alternate.
- Writes never alter mX_rdata. A read with zero wait states still captures correctly.
- Reset asserted in any state:
  - All outputs go to 0 immediately: s_valid, gnt, done, err, rdata registers, and s_* fields.
  - FSM → IDLE. The in-flight transaction is dropped with no done pulse.

## Timing
- All outputs are registered or decoded from registered state. No combinational path runs from mX_req or s_ready to any output.
- Cycle numbering, for a request sampled at edge E:
  - s_valid is high from E+1.
  - With s_ready high in the first ACCESS cycle, RESP is entered at E+2. mX_done is high during E+2..E+3.
  - FSM is back in IDLE at E+3.
- Minimum transaction: 3 cycles. Each slave wait cycle adds 1.
- Sustained throughput: one transfer per 3 cycles with a zero-wait slave.
- The core must stall while mX_req is high and mX_done is low.

## Configuration
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with s_ready = 0.
  - When the count reaches TIMEOUT: go to RESP with mX_err = 1 alongside mX_done, and owner rdata forced to 0.
  - A late s_ready arriving after the abort is ignored.
- Undefined: no counter is implemented, ACCESS waits indefinitely, and mX_err is tied to 0.

## Test plan
- m0 read of 0x0000_1000, zero-wait slave returning 0x1234_5678 → s_valid for 1 cycle with s_addr 0x1000 and s_we 0; m0_done pulse 2 cycles after sampling; m0_rdata = 0x1234_5678; m1 outputs stay 0.
- m0 and m1 request together right after reset and hold req → grant order m0, m1, m0, m1; never two consecutive grants to one master.
- m1 write to 0x0000_2004, wdata 0xA5A5_A5A5, strb 3'b001, slave with 3 wait states → s_valid high 4 cycles with s_we 1 and all fields stable; m1_done 1 cycle later; m1_rdata unchanged.
- m0 changes addr from 0x10 to 0x20 during ACCESS → s_addr stays 0x10 until done.
- reset pulse mid-ACCESS → s_valid and m0_gnt fall during reset; no m0_done; after release, a tie is granted to m0.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT = 8, s_ready held 0 → m0_done and m0_err pulse after 8 ACCESS cycles with m0_rdata = 0. Without the macro → still in ACCESS after 100 cycles, err = 0.
